// File: rtl/token_scheduler_pkg.sv
// Shared types and helpers for the token scheduler slice.
// Optional feature macro used elsewhere: TOKEN_SCHEDULER_STATS_EN.
package token_scheduler_pkg;

    // Default configuration of the scheduler.
    localparam int DEF_N_REQ = 4;
    localparam int DEF_CNT_W = 4;
    localparam int DEF_MULT  = 2;

    // The round-robin helper works on a fixed-width mask so that one
    // function serves every N_REQ up to MAX_REQ.
    localparam int MAX_REQ  = 32;
    localparam int ID_MAX_W = 5;

    typedef logic [$clog2(DEF_N_REQ)-1:0] req_id_t;
    typedef logic [DEF_CNT_W-1:0]         cnt_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic                found;
        logic [ID_MAX_W-1:0] id;
    } rr_pick_t;

    // First set bit of mask[n-1:0], scanning ptr+1, ptr+2, ... with wrap.
    // Returns found=0 when no bit is set in the active range.
    function automatic rr_pick_t rr_pick(
        input logic [MAX_REQ-1:0]  mask,
        input logic [ID_MAX_W-1:0] ptr,
        input int unsigned         n
    );
        rr_pick_t    res;
        int unsigned idx;
        res = '0;
        idx = 0;
        for (int unsigned k = 1; k <= MAX_REQ; k++) begin
            if ((k <= n) && !res.found) begin
                idx = (32'(ptr) + k) % n;
                if (mask[idx[ID_MAX_W-1:0]]) begin
                    res.found = 1'b1;
                    res.id    = idx[ID_MAX_W-1:0];
                end
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/token_scheduler_if.sv
// Output token channel of the token scheduler.
// Handshake: a token transfers on every rising clk edge where b_valid and
// b_ready are both 1; while b_valid=1 and b_ready=0 the master holds b_valid
// and b_id stable, and b_valid never depends combinationally on b_ready.
interface token_scheduler_if #(
    parameter int N_REQ = 4
) ();
    logic                     b_valid;
    logic                     b_ready;
    logic [$clog2(N_REQ)-1:0] b_id;

    modport master (
        output b_valid,
        output b_id,
        input  b_ready
    );

    modport slave (
        input  b_valid,
        input  b_id,
        output b_ready
    );
endinterface

// File: rtl/token_credit_counter.sv
// Per-requester pending-token counter with saturation and sticky overflow.
// Adds MULT on inc_i, subtracts 1 on dec_i, both in the same cycle allowed.
module token_credit_counter
    import token_scheduler_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W,
    parameter int MULT  = DEF_MULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             nonzero_o,   // next-state count is non-zero
    output logic             overflow_o
);

    localparam logic [CNT_W:0] INC_AMT = MULT[CNT_W:0];
    localparam logic [CNT_W:0] CNT_MAX = {1'b0, {CNT_W{1'b1}}};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             ovf_q;
    logic             ovf_d;
    logic [CNT_W:0]   sum_w;
    logic             sat_w;

    // One extra bit of headroom so saturation can be detected before clamping.
    always_comb begin
        sum_w = {1'b0, cnt_q}
              + (inc_i ? INC_AMT : {(CNT_W+1){1'b0}})
              - {{CNT_W{1'b0}}, dec_i};
        sat_w = (sum_w > CNT_MAX);
        cnt_d = sat_w ? CNT_MAX[CNT_W-1:0] : sum_w[CNT_W-1:0];
        ovf_d = ovf_q | sat_w;
    end

    // Count and sticky overflow registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o      = cnt_q;
    assign nonzero_o  = |cnt_d;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/token_scheduler.sv
// Round-robin token scheduler: each a[i] pulse credits MULT tokens to
// requester i; pending tokens leave one per handshake on the output channel.
// Optional macro TOKEN_SCHEDULER_STATS_EN adds n_emitted, a wrapping count
// of handshakes since reset.
module token_scheduler
    import token_scheduler_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int CNT_W = DEF_CNT_W,
    parameter int MULT  = DEF_MULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     a,
    token_scheduler_if.master    bus,
    output logic [N_REQ-1:0]     overflow,
    output logic                 busy,
`ifdef TOKEN_SCHEDULER_STATS_EN
    output logic [31:0]          n_emitted,
`endif
    output logic [0:0]           dbg_state_o
);

    localparam int ID_W = $clog2(N_REQ);

    localparam logic [0:0]      ST_IDLE  = IDLE;
    localparam logic [0:0]      ST_OFFER = OFFER;
    localparam logic [ID_W-1:0] PTR_RST  = ID_W'(N_REQ - 1);

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [ID_W-1:0] b_id_q;
    logic [ID_W-1:0] b_id_d;
    logic [ID_W-1:0] rr_ptr_q;
    logic [ID_W-1:0] rr_ptr_d;

    logic             hs;
    logic [N_REQ-1:0] dec_vec;
    logic [N_REQ-1:0] nxt_nz;
    logic [N_REQ-1:0] cur_nz;
    logic [CNT_W-1:0] cnt_arr [N_REQ];

    logic [MAX_REQ-1:0]  pick_mask;
    logic [ID_MAX_W-1:0] pick_ptr;
    rr_pick_t            pick;

    assign hs = (state_q == ST_OFFER) && bus.b_ready;

    // One credit counter per requester; a handshake decrements the owner only.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        localparam logic [ID_W-1:0] MY_ID = ID_W'(gi);

        assign dec_vec[gi] = hs && (b_id_q == MY_ID);

        token_credit_counter #(
            .CNT_W (CNT_W),
            .MULT  (MULT)
        ) u_cnt (
            .clk        (clk),
            .rst_n      (rst_n),
            .inc_i      (a[gi]),
            .dec_i      (dec_vec[gi]),
            .cnt_o      (cnt_arr[gi]),
            .nonzero_o  (nxt_nz[gi]),
            .overflow_o (overflow[gi])
        );

        assign cur_nz[gi] = |cnt_arr[gi];
    end

    // Round-robin search over next-state counts. While offering, the search
    // starts after the current owner (which becomes the new rr pointer on a
    // handshake); while idle it starts after the last served requester.
    always_comb begin
        pick_mask             = '0;
        pick_mask[N_REQ-1:0]  = nxt_nz;
        pick_ptr              = (state_q == ST_OFFER) ? ID_MAX_W'(b_id_q)
                                                      : ID_MAX_W'(rr_ptr_q);
        pick                  = rr_pick(pick_mask, pick_ptr, N_REQ);
    end

    // FSM next state: b_id only moves on a handshake or on IDLE->OFFER.
    always_comb begin
        state_d  = state_q;
        b_id_d   = b_id_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (pick.found) begin
                    state_d = ST_OFFER;
                    b_id_d  = ID_W'(pick.id);
                end
            end
            ST_OFFER: begin
                if (bus.b_ready) begin
                    rr_ptr_d = b_id_q;
                    if (pick.found) begin
                        b_id_d = ID_W'(pick.id);
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, owner id and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            b_id_q   <= '0;
            rr_ptr_q <= PTR_RST;
        end else begin
            state_q  <= state_d;
            b_id_q   <= b_id_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign bus.b_valid = (state_q == ST_OFFER);
    assign bus.b_id    = b_id_q;
    assign busy        = (|cur_nz) || (state_q == ST_OFFER);
    assign dbg_state_o = state_q;

`ifdef TOKEN_SCHEDULER_STATS_EN
    logic [31:0] n_emitted_q;

    // Handshake counter, wraps naturally at 2**32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_emitted_q <= '0;
        end else if (hs) begin
            n_emitted_q <= n_emitted_q + 32'd1;
        end
    end

    assign n_emitted = n_emitted_q;
`endif

endmodule
